// File: rtl/uart_frame_pkg.sv
// Shared types and default constants for the UART frame sequencer.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        ACK    = 2'd3
    } state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h5A;

    typedef struct packed {
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } rgb_t;

endpackage

// File: rtl/uart_frame_seq_if.sv
// Handshake bundle between the frame sequencer and its UART / pixel / result neighbours.
interface uart_frame_seq_if;
    logic        rx_valid_i;
    logic [7:0]  rx_data_i;
    logic        rx_ready_o;
    logic        pix_valid_o;
    logic [23:0] pix_data_o;
    logic        pix_ready_i;
    logic        res_valid_i;
    logic [7:0]  res_data_i;
    logic        res_ready_o;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i;
    logic        busy_o;
    logic        frame_done_o;
    logic        err_o;

    modport slave (
        input  rx_valid_i, rx_data_i, pix_ready_i, res_valid_i, res_data_i, tx_ready_i,
        output rx_ready_o, pix_valid_o, pix_data_o, res_ready_o, tx_valid_o, tx_data_o,
               busy_o, frame_done_o, err_o
    );

    modport master (
        output rx_valid_i, rx_data_i, pix_ready_i, res_valid_i, res_data_i, tx_ready_i,
        input  rx_ready_o, pix_valid_o, pix_data_o, res_ready_o, tx_valid_o, tx_data_o,
               busy_o, frame_done_o, err_o
    );
endinterface

// File: rtl/uart_frame_seq_packer.sv
// Packs R,G,B byte triplets into one 24-bit pixel held in a single output register.
module rgb_packer
    import uart_frame_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output rgb_t       out_data,
    input  logic       out_ready,
    output logic       last
);

    logic [1:0] cnt_p0;
    logic [7:0] r_p0;
    logic [7:0] g_p0;
    logic       vld_p1;
    rgb_t       pix_p1;
    logic       acc;

    // The closing byte may only land when the pixel register is free or emptying now.
    assign in_ready  = en && ((cnt_p0 != 2'd2) || !vld_p1 || out_ready);
    assign acc       = in_valid && in_ready;
    assign last      = acc && (cnt_p0 == 2'd2);
    assign out_valid = vld_p1;
    assign out_data  = pix_p1;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_p0 <= 2'd0;
            r_p0   <= '0;
            g_p0   <= '0;
            vld_p1 <= 1'b0;
            pix_p1 <= '0;
        end else begin
            if (vld_p1 && out_ready)
                vld_p1 <= 1'b0;
            if (acc) begin
                case (cnt_p0)
                    2'd0: begin
                        r_p0   <= in_data;
                        cnt_p0 <= 2'd1;
                    end
                    2'd1: begin
                        g_p0   <= in_data;
                        cnt_p0 <= 2'd2;
                    end
                    default: begin
                        pix_p1 <= '{b: in_data, g: g_p0, r: r_p0};
                        vld_p1 <= 1'b1;
                        cnt_p0 <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_frame_seq.sv
// Frame sequencer: sync on a marker byte, pack one frame of pixels, forward and count
// magnitude bytes, then emit an ack byte once the whole frame has come back.
module uart_frame_seq
    import uart_frame_pkg::*;
#(
    parameter int         linewidth_px_p = 480,
    parameter int         lines_p        = 480,
    parameter int         out_count_p    = linewidth_px_p * lines_p,
    parameter logic [7:0] sync_byte_p    = SYNC_BYTE,
    parameter logic [7:0] ack_byte_p     = ACK_BYTE
) (
    input  logic             clk_i,
    input  logic             reset_i,
    uart_frame_seq_if.slave  bus
);

    localparam int COL_W = $clog2(linewidth_px_p + 1);
    localparam int ROW_W = $clog2(lines_p + 1);
    localparam int RES_W = $clog2(out_count_p + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(linewidth_px_p - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(lines_p - 1);
    localparam logic [RES_W-1:0] RES_FULL = RES_W'(out_count_p);

    state_e           state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [RES_W-1:0] res_cnt;
    logic [RES_W-1:0] res_cnt_nxt;
    logic             err;

    logic             pk_en;
    logic             pk_in_ready;
    logic             pk_last;
    logic             pk_valid;
    rgb_t             pk_data;
    logic             rx_ready;
    logic             res_ready;
    logic             res_hs;
    logic             last_pix;

    assign pk_en = (state == STREAM);

    rgb_packer u_packer (
        .clk       (clk_i),
        .reset     (reset_i),
        .en        (pk_en),
        .in_valid  (bus.rx_valid_i && pk_en),
        .in_data   (bus.rx_data_i),
        .in_ready  (pk_in_ready),
        .out_valid (pk_valid),
        .out_data  (pk_data),
        .out_ready (bus.pix_ready_i),
        .last      (pk_last)
    );

    always_comb begin
        rx_ready = 1'b0;
        case (state)
            IDLE:    rx_ready = 1'b1;
            STREAM:  rx_ready = pk_in_ready;
            DRAIN:   rx_ready = 1'b1;
            default: rx_ready = 1'b0;
        endcase
    end

    assign res_ready = (state != ACK) && bus.tx_ready_i;
    assign res_hs    = bus.res_valid_i && res_ready;
    assign last_pix  = pk_last && (col == COL_LAST) && (row == ROW_LAST);

    // Results seen in the exit-check cycle must already be included in the count.
    always_comb begin
        res_cnt_nxt = res_cnt;
        if (res_hs && (state == STREAM || state == DRAIN) && res_cnt != RES_FULL)
            res_cnt_nxt = res_cnt + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state   <= IDLE;
            col     <= '0;
            row     <= '0;
            res_cnt <= '0;
            err     <= 1'b0;
        end else begin
            res_cnt <= res_cnt_nxt;
            if (pk_last) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            case (state)
                IDLE: begin
                    if (bus.rx_valid_i && bus.rx_data_i == sync_byte_p)
                        state <= STREAM;
                end
                STREAM: begin
                    if (last_pix)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (bus.rx_valid_i)
                        err <= 1'b1;
                    if (res_cnt_nxt == RES_FULL && !pk_valid)
                        state <= ACK;
                end
                default: begin
                    if (bus.tx_ready_i) begin
                        state   <= IDLE;
                        col     <= '0;
                        row     <= '0;
                        res_cnt <= '0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        bus.tx_valid_o = bus.res_valid_i;
        bus.tx_data_o  = bus.res_data_i;
        if (state == ACK) begin
            bus.tx_valid_o = 1'b1;
            bus.tx_data_o  = ack_byte_p;
        end
    end

    assign bus.rx_ready_o   = rx_ready;
    assign bus.res_ready_o  = res_ready;
    assign bus.pix_valid_o  = pk_valid;
    assign bus.pix_data_o   = pk_data;
    assign bus.busy_o       = (state != IDLE);
    assign bus.frame_done_o = (state == ACK) && bus.tx_ready_i;
    assign bus.err_o        = err;

endmodule
